// File: rtl/mem_region_decoder.sv
// -----------------------------------------------------------------------------
// mem_region_decoder
//
// Registered address decoder for the core's memory map. Each request is
// matched against NUM_REGIONS equally sized regions. One cycle later the block
// presents:
//   - a one-hot chip select
//   - the word index inside the selected region
//   - misaligned / unmapped fault flags
// It also keeps:
//   - a sticky record of the first faulting address
//   - saturating per-region hit counters for debug
//
// Handshake: req_valid qualifies req_addr and fault_clr is a plain strobe.
// There is no ready. Every cycle with req_valid high is accepted, and
// dec_valid pulses exactly one cycle later for that request. dec_valid is the
// only qualifier for cs / word_index / fault / fault_code.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   req_valid    in   request strobe
//   req_addr     in   32-bit byte address
//   fault_clr    in   clears fault_sticky / fault_addr
//   cs           out  one-hot region select (0 when idle or faulting)
//   word_index   out  (req_addr - base) >> 2 of the hit region, else 0
//   dec_valid    out  one-cycle-delayed copy of req_valid
//   fault        out  pulse for a misaligned or unmapped request
//   fault_code   out  {misaligned, unmapped}
//   fault_sticky out  set by the first fault since the last clear
//   fault_addr   out  address of that first fault
//   hit_count    out  packed saturating hit counters, region i at [CNT_W*i +: CNT_W]
// -----------------------------------------------------------------------------
module mem_region_decoder #(
  parameter int unsigned                 NUM_REGIONS  = 2,
  parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE  = {32'h00002240, 32'h00000240},
  parameter int unsigned                 REGION_BYTES = 4096,
  parameter int unsigned                 INDEX_W      = 10,
  parameter int unsigned                 CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [31:0]                  req_addr,
  input  logic                         fault_clr,
  output logic [NUM_REGIONS-1:0]       cs,
  output logic [INDEX_W-1:0]           word_index,
  output logic                         dec_valid,
  output logic                         fault,
  output logic [1:0]                   fault_code,
  output logic                         fault_sticky,
  output logic [31:0]                  fault_addr,
  output logic [NUM_REGIONS*CNT_W-1:0] hit_count
);

  // Registered state
  logic [NUM_REGIONS-1:0]       cs_q,     cs_d;
  logic [INDEX_W-1:0]           wi_q,     wi_d;
  logic                         dv_q,     dv_d;
  logic                         fault_q,  fault_d;
  logic [1:0]                   code_q,   code_d;
  logic                         sticky_q, sticky_d;
  logic [31:0]                  faddr_q,  faddr_d;
  logic [NUM_REGIONS*CNT_W-1:0] cnt_q,    cnt_d;

  // Decode results for the current request
  logic [NUM_REGIONS-1:0] hit_sel;
  logic                   any_hit;
  logic [INDEX_W-1:0]     hit_idx;
  logic [32:0]            addr33;
  logic [32:0]            base33;
  logic [32:0]            top33;
  logic                   misaligned;
  logic                   unmapped;
  logic                   fault_now;
  logic                   good_req;

  // Region match. Bounds are compared in 33 bits so a region ending at
  // 2^32 - 1 does not wrap. The ascending scan with the any_hit guard gives
  // priority to the lowest index when regions overlap, which keeps cs one-hot.
  always_comb begin
    addr33  = {1'b0, req_addr};
    base33  = '0;
    top33   = '0;
    hit_sel = '0;
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      base33 = {1'b0, REGION_BASE[32*i +: 32]};
      top33  = base33 + 33'(REGION_BYTES - 1);
      if (!any_hit && (addr33 >= base33) && (addr33 <= top33)) begin
        any_hit    = 1'b1;
        hit_sel[i] = 1'b1;
        hit_idx    = INDEX_W'((req_addr - REGION_BASE[32*i +: 32]) >> 2);
      end
    end
  end

  assign misaligned = |req_addr[1:0];
  assign unmapped   = ~any_hit;
  assign fault_now  = misaligned | unmapped;
  assign good_req   = req_valid & ~fault_now;

  always_comb begin
    cs_d     = good_req ? hit_sel : '0;
    wi_d     = good_req ? hit_idx : '0;
    dv_d     = req_valid;
    fault_d  = req_valid & fault_now;
    code_d   = req_valid ? {misaligned, unmapped} : 2'b00;
    sticky_d = sticky_q;
    faddr_d  = faddr_q;
    // A new fault is captured when nothing is latched, or when the latch is
    // being cleared in the same cycle: the new fault takes precedence.
    if (req_valid && fault_now && (!sticky_q || fault_clr)) begin
      sticky_d = 1'b1;
      faddr_d  = req_addr;
    end else if (fault_clr) begin
      sticky_d = 1'b0;
      faddr_d  = '0;
    end
  end

  // Saturating hit counters; only a clean hit advances its region's counter.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      if (cs_d[i] && (cnt_q[CNT_W*i +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_d[CNT_W*i +: CNT_W] = cnt_q[CNT_W*i +: CNT_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q     <= '0;
      wi_q     <= '0;
      dv_q     <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= 2'b00;
      sticky_q <= 1'b0;
      faddr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      cs_q     <= cs_d;
      wi_q     <= wi_d;
      dv_q     <= dv_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      sticky_q <= sticky_d;
      faddr_q  <= faddr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cs           = cs_q;
  assign word_index   = wi_q;
  assign dec_valid    = dv_q;
  assign fault        = fault_q;
  assign fault_code   = code_q;
  assign fault_sticky = sticky_q;
  assign fault_addr   = faddr_q;
  assign hit_count    = cnt_q;

endmodule

// File: tb/tb_mem_region_decoder.sv
// -----------------------------------------------------------------------------
// Bench for mem_region_decoder with the default memory map:
//   region 0 = 0x0240..0x123F
//   region 1 = 0x2240..0x323F
// CNT_W is set to 4 so that counter saturation can be reached.
// Drivers push a hand-computed expected record per request; a negedge monitor
// pops a record whenever dec_valid is high and checks idle outputs otherwise.
// -----------------------------------------------------------------------------
module tb_mem_region_decoder;

  localparam int NR    = 2;
  localparam int IW    = 10;
  localparam int CW    = 4;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic [31:0]       req_addr;
  logic              fault_clr;
  logic [NR-1:0]     cs;
  logic [IW-1:0]     word_index;
  logic              dec_valid;
  logic              fault;
  logic [1:0]        fault_code;
  logic              fault_sticky;
  logic [31:0]       fault_addr;
  logic [NR*CW-1:0]  hit_count;

  typedef struct packed {
    logic [NR-1:0]    cs;
    logic [IW-1:0]    wi;
    logic             f;
    logic [1:0]       code;
    logic             sticky;
    logic [31:0]      addr;
    logic [NR*CW-1:0] hc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  mem_region_decoder #(
    .NUM_REGIONS (NR),
    .REGION_BASE ({32'h00002240, 32'h00000240}),
    .REGION_BYTES(4096),
    .INDEX_W     (IW),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .fault_clr   (fault_clr),
    .cs          (cs),
    .word_index  (word_index),
    .dec_valid   (dec_valid),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_sticky(fault_sticky),
    .fault_addr  (fault_addr),
    .hit_count   (hit_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*CW-1:0] hc(input int h1, input int h0);
    return {CW'(h1), CW'(h0)};
  endfunction

  function automatic exp_t mk(input logic [NR-1:0] c, input logic [IW-1:0] w,
                              input logic f, input logic [1:0] code,
                              input logic s, input logic [31:0] a,
                              input logic [NR*CW-1:0] h);
    exp_t e;
    e.cs = c; e.wi = w; e.f = f; e.code = code; e.sticky = s; e.addr = a; e.hc = h;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic clr, input exp_t e);
    req_valid = 1'b1;
    req_addr  = a;
    fault_clr = clr;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = '0;
    fault_clr = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    fault_clr = 1'b1;
    @(posedge clk); #1;
    fault_clr = 1'b0;
    check("clr_sticky", 64'(fault_sticky), 64'd0);
    check("clr_addr",   64'(fault_addr),   64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cs"},     64'(cs),           64'd0);
    check({tag, "_wi"},     64'(word_index),   64'd0);
    check({tag, "_dv"},     64'(dec_valid),    64'd0);
    check({tag, "_fault"},  64'(fault),        64'd0);
    check({tag, "_code"},   64'(fault_code),   64'd0);
    check({tag, "_sticky"}, 64'(fault_sticky), 64'd0);
    check({tag, "_faddr"},  64'(fault_addr),   64'd0);
    check({tag, "_hc"},     64'(hit_count),    64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (dec_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dec_valid: act=1 exp=0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("cs",         64'(cs),           64'(e.cs));
          check("word_index", 64'(word_index),   64'(e.wi));
          check("fault",      64'(fault),        64'(e.f));
          check("fault_code", 64'(fault_code),   64'(e.code));
          check("sticky",     64'(fault_sticky), 64'(e.sticky));
          check("fault_addr", 64'(fault_addr),   64'(e.addr));
          check("hit_count",  64'(hit_count),    64'(e.hc));
        end
      end else begin
        check("idle_cs",    64'(cs),         64'd0);
        check("idle_wi",    64'(word_index), 64'd0);
        check("idle_fault", 64'(fault),      64'd0);
        check("idle_code",  64'(fault_code), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");
    mon_en = 1'b1;

    // First word of region 0
    send(32'h0000_0240, 1'b0, mk(2'b01, 10'h000, 1'b0, 2'b00, 1'b0, 32'h0, hc(0, 1)));
    // Last word of region 0, then first byte past it (back-to-back)
    send(32'h0000_123C, 1'b0, mk(2'b01, 10'h3FF, 1'b0, 2'b00, 1'b0, 32'h0, hc(0, 2)));
    send(32'h0000_1240, 1'b0, mk(2'b00, 10'h000, 1'b1, 2'b01, 1'b1, 32'h1240, hc(0, 2)));
    idle_cycle();
    clear_pulse();

    // Misaligned inside region 1, then misaligned + unmapped
    send(32'h0000_2242, 1'b0, mk(2'b00, 10'h000, 1'b1, 2'b10, 1'b1, 32'h2242, hc(0, 2)));
    send(32'h0000_9999, 1'b0, mk(2'b00, 10'h000, 1'b1, 2'b11, 1'b1, 32'h2242, hc(0, 2)));
    clear_pulse();

    // Region 1 interior and last word
    send(32'h0000_3000, 1'b0, mk(2'b10, 10'h370, 1'b0, 2'b00, 1'b0, 32'h0, hc(1, 2)));
    send(32'h0000_323C, 1'b0, mk(2'b10, 10'h3FF, 1'b0, 2'b00, 1'b0, 32'h0, hc(2, 2)));
    // Just past region 1 latches a fault
    send(32'h0000_3240, 1'b0, mk(2'b00, 10'h000, 1'b1, 2'b01, 1'b1, 32'h3240, hc(2, 2)));
    // Clear together with a new fault: the new fault wins
    send(32'h0000_023C, 1'b1, mk(2'b00, 10'h000, 1'b1, 2'b01, 1'b1, 32'h023C, hc(2, 2)));

    // Saturate region 1's counter; region 0 stays at 2
    for (int k = 1; k <= 20; k++) begin
      int h1;
      h1 = (2 + k > 15) ? 15 : 2 + k;
      send(32'h0000_2240, 1'b0, mk(2'b10, 10'h000, 1'b0, 2'b00, 1'b1, 32'h023C, hc(h1, 2)));
    end
    idle_cycle();

    // Reset collides with a request: nothing from it may emerge
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0244;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    check_reset_state("rst_req");
    idle_cycle();
    idle_cycle();
    check("post_rst_dv", 64'(dec_valid), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_region_decoder.md
# mem_region_decoder

Registered, parametrised address decoder for the RISC-V core's memory map. It generalises single-region program-memory decoding to NUM_REGIONS regions and produces a one-hot chip select plus a word index one cycle after each request. It also flags misaligned and unmapped accesses, captures the first faulting address in a sticky fault register, and keeps saturating per-region hit counters for debug. It sits between the core's address outputs and the instruction/data memory selects.

## Interface
- NUM_REGIONS, 2, number of decoded regions (1..8).
- REGION_BASE, {32'h00002240, 32'h00000240}, packed NUM_REGIONS×32 byte base addresses; region i is bits [32i+31:32i]; each base is word-aligned.
- REGION_BYTES, 4096, size of every region in bytes; a power of two, ≥ 4.
- INDEX_W, 10, word-index width; equals log2(REGION_BYTES/4).
- CNT_W, 16, hit-counter width.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  address presented this cycle.
- req_addr  in  32  byte address.
- fault_clr  in  1  clears sticky fault state.
- cs  out  NUM_REGIONS  registered one-hot chip select; all zero when idle or on a fault.
- word_index  out  INDEX_W  registered (req_addr − base) >> 2 of the hit region; 0 otherwise.
- dec_valid  out  1  registered; high exactly one cycle after each accepted req_valid.
- fault  out  1  registered one-cycle pulse for a misaligned or unmapped request.
- fault_code  out  2  registered; 00 none, 01 unmapped, 10 misaligned, 11 both.
- fault_sticky  out  1  set by the first fault; held until fault_clr or rst.
- fault_addr  out  32  req_addr of the first fault since the last clear.
- hit_count  out  NUM_REGIONS×CNT_W  packed saturating per-region hit counters.

## Operation
- Region i hits when REGION_BASE[i] ≤ req_addr ≤ REGION_BASE[i] + REGION_BYTES − 1.
  - Compare in 33 bits so that base + size near 2^32 does not wrap.
  - Overlapping regions resolve to the lowest index; cs stays one-hot.
- Misaligned means req_addr[1:0] ≠ 0. Unmapped means no region hits.
- For a valid request with no fault:
  - cs[i] = 1.
  - word_index = (req_addr − REGION_BASE[i]) >> 2, truncated to INDEX_W.
  - hit_count[i] increments, saturating at 2^CNT_W − 1 (it holds there and does not wrap).
- For a valid request with a fault:
  - cs = 0, word_index = 0, fault = 1, fault_code set as defined above.
  - hit counters do not change.
  - If fault_sticky was 0, set fault_sticky and capture fault_addr = req_addr.
  - Later faults leave fault_addr unchanged.
- A misaligned address inside a region is still a fault: fault_code = 10 and cs = 0.
- With req_valid low, the next cycle has cs = 0, word_index = 0, dec_valid = 0, fault = 0, fault_code = 00.
- fault_clr clears fault_sticky to 0 and fault_addr to 0.
  - If fault_clr and a faulting request arrive in the same cycle, the new fault wins: sticky = 1 and fault_addr = the new address.
- The block has no back-pressure. It accepts one request every cycle, back-to-back.

## Timing
- Latency is 1 cycle: a request in cycle N appears on cs, word_index, dec_valid, fault and fault_code in cycle N+1.
- fault_sticky, fault_addr and hit_count update at the same edge, so they are visible in cycle N+1.
- Reset values: cs = 0, word_index = 0, dec_valid = 0, fault = 0, fault_code = 00, fault_sticky = 0, fault_addr = 0, all hit_count = 0.
- rst asserted at edge N overrides any req_valid or fault_clr in that cycle. An in-flight request is discarded and produces no dec_valid after reset.
- Outputs are driven only from registers; there are no combinational paths from input to output.

## Test plan
- Reset, then req 0x240 → next cycle: cs = 01, word_index = 0, dec_valid = 1, hit_count[0] = 1.
- Req 0x123C then 0x1240 on consecutive cycles:
  - 0x123C → cs = 01, word_index = 0x3FF.
  - 0x1240 → cs = 00, fault = 1, fault_code = 01, fault_sticky = 1, fault_addr = 0x1240.
- Req 0x2242 → fault_code = 10, cs = 00.
- Then req 0x9999 → fault_code = 11, with fault_addr still 0x2242.
- Pulse fault_clr with no request → fault_sticky = 0, fault_addr = 0.
- Pulse fault_clr together with req 0x23C → sticky = 1, fault_addr = 0x23C.
- With CNT_W = 4, send 20 hits to 0x2240 → hit_count[1] saturates at 15; hit_count[0] is unchanged.
- Assert rst in the same cycle as a req to 0x244 → the next cycle shows all outputs at their reset values and dec_valid = 0.
